sample_source: RTL and testbench

- Producer end of the filter's sample-input req/gnt interface.
- Buffers samples written by software or DMA into an internal FIFO.
- At a programmable sample rate, pops one sample and presents it on `data_out_o` with `data_out_req_o` until the filter grants it.
- Counts underruns (no sample ready at a tick) and stalls (tick arrives while a request is still ungranted).

---
 rtl/filter_pkg.sv | 15 +
 rtl/sample_fifo.sv | 49 ++++
 rtl/sample_source.sv | 100 ++++++++++
 tb/tb_sample_source.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Constants and types shared between the sample source and the filter it feeds.
package filter_pkg;

    localparam int DataWidth = 16;
    localparam int RateWidth = 16;
    localparam int CntWidth  = 16;

    typedef logic [DataWidth-1:0] sample_t;

    typedef enum logic {
        IDLE,
        REQ
    } src_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Register-array FIFO with wrap-flag pointers; pop data is the registered head.
module sample_fifo #(
    parameter int DataWidth = 16,
    parameter int Depth     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push,
    input  logic [DataWidth-1:0]   push_data,
    output logic                   full,
    input  logic                   pop,
    output logic [DataWidth-1:0]   pop_data,
    output logic                   empty,
    output logic [$clog2(Depth):0] fill
);

    localparam int AddrWidth = $clog2(Depth);

    logic [AddrWidth:0]   wr_ptr;
    logic [AddrWidth:0]   rd_ptr;
    logic [DataWidth-1:0] mem [Depth];
    logic                 do_push;
    logic                 do_pop;

    // Pointers carry one extra MSB so equal low bits can mean either full or empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AddrWidth] != rd_ptr[AddrWidth]) &&
                   (wr_ptr[AddrWidth-1:0] == rd_ptr[AddrWidth-1:0]);
    assign fill  = wr_ptr - rd_ptr;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AddrWidth-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AddrWidth+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AddrWidth+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) mem[wr_ptr[AddrWidth-1:0]] <= push_data;
    end

endmodule

// File: rtl/sample_source.sv
// Producer side of the filter sample input: buffers samples and offers one per rate tick.
module sample_source
    import filter_pkg::*;
#(
    parameter int DataWidth = filter_pkg::DataWidth,
    parameter int Depth     = 16,
    parameter int RateWidth = filter_pkg::RateWidth,
    parameter int CntWidth  = filter_pkg::CntWidth
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic [RateWidth-1:0]   rate_div_i,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    input  logic [DataWidth-1:0]   wr_data_i,
    output logic                   data_out_req_o,
    input  logic                   data_out_gnt_i,
    output logic [DataWidth-1:0]   data_out_o,
    output logic [$clog2(Depth):0] fill_o,
    output logic [CntWidth-1:0]    underrun_cnt_o,
    output logic [CntWidth-1:0]    stall_cnt_o
);

    // Handshakes: a write moves when wr_valid_i && wr_ready_o on a clock edge.
    // Once data_out_req_o rises, it and data_out_o stay stable until the edge
    // where data_out_gnt_i is high; that edge completes the transfer.

    src_state_e           state_q;
    logic [RateWidth-1:0] tick_cnt;
    logic                 tick;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [DataWidth-1:0] fifo_head;

    assign tick       = enable_i && (tick_cnt == rate_div_i);
    assign wr_ready_o = !fifo_full;
    assign fifo_push  = wr_valid_i && wr_ready_o;
    assign fifo_pop   = (state_q == IDLE) && tick && !fifo_empty;

    sample_fifo #(
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (fifo_push),
        .push_data (wr_data_i),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .fill      (fill_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || !enable_i || tick) tick_cnt <= '0;
        else                            tick_cnt <= tick_cnt + RateWidth'(1);
    end

    // Ticks that land while a request is outstanding are dropped, never queued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            data_out_req_o <= 1'b0;
            data_out_o     <= '0;
            underrun_cnt_o <= '0;
            stall_cnt_o    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        if (!fifo_empty) begin
                            data_out_o     <= fifo_head;
                            data_out_req_o <= 1'b1;
                            state_q        <= REQ;
                        end else if (underrun_cnt_o != '1) begin
                            underrun_cnt_o <= underrun_cnt_o + CntWidth'(1);
                        end
                    end
                end
                REQ: begin
                    if (data_out_gnt_i) begin
                        data_out_req_o <= 1'b0;
                        state_q        <= IDLE;
                    end else if (tick && stall_cnt_o != '1) begin
                        stall_cnt_o <= stall_cnt_o + CntWidth'(1);
                    end
                end
                default: begin
                    data_out_req_o <= 1'b0;
                    state_q        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_source.sv
// Bench for sample_source: directed scenarios plus random traffic against a queue-based model.
module tb_sample_source;

    localparam int DW      = 16;
    localparam int DEPTH   = 16;
    localparam int RW      = 16;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [RW-1:0] rate_div;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          req;
    logic          gnt;
    logic [DW-1:0] data_out;
    logic [4:0]    fill;
    logic [CW-1:0] under;
    logic [CW-1:0] stall;

    always #5 clk = ~clk;

    sample_source #(
        .DataWidth (DW),
        .Depth     (DEPTH),
        .RateWidth (RW),
        .CntWidth  (CW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .rate_div_i     (rate_div),
        .wr_valid_i     (wr_valid),
        .wr_ready_o     (wr_ready),
        .wr_data_i      (wr_data),
        .data_out_req_o (req),
        .data_out_gnt_i (gnt),
        .data_out_o     (data_out),
        .fill_o         (fill),
        .underrun_cnt_o (under),
        .stall_cnt_o    (stall)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: FIFO as a queue, request as a busy flag, counters as ints.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] exp_q[$];
    int            m_tick_cnt;
    bit            m_busy;
    logic [DW-1:0] m_data;
    int            m_under;
    int            m_stall;
    int            req_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit tick;
        bit push_ok;
        if (!rst && req === 1'b1 && gnt) begin
            if (exp_q.size() == 0) check("xfer_unexpected", 32'd1, 32'd0);
            else                   check("xfer_data", data_out, exp_q.pop_front());
        end
        if (req === 1'b1) req_seen++;
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_tick_cnt = 0;
            m_busy     = 0;
            m_data     = '0;
            m_under    = 0;
            m_stall    = 0;
        end else begin
            tick    = enable && (m_tick_cnt == int'(rate_div));
            push_ok = wr_valid && (m_q.size() < DEPTH);
            if (m_busy) begin
                if (gnt) m_busy = 0;
                else if (tick && m_stall < CNT_MAX) m_stall++;
            end else if (tick) begin
                if (m_q.size() > 0) begin
                    m_data = m_q.pop_front();
                    m_busy = 1;
                end else if (m_under < CNT_MAX) begin
                    m_under++;
                end
            end
            if (push_ok) begin
                m_q.push_back(wr_data);
                exp_q.push_back(wr_data);
            end
            if (!enable || tick) m_tick_cnt = 0;
            else                 m_tick_cnt = (m_tick_cnt + 1) % (1 << RW);
        end
        @(posedge clk);
        #1;
        check("req", req, m_busy);
        check("data_out", data_out, m_data);
        check("fill", fill, m_q.size());
        check("wr_ready", wr_ready, m_q.size() < DEPTH);
        check("underrun_cnt", under, m_under);
        check("stall_cnt", stall, m_stall);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        enable   = 1'b0;
        wr_valid = 1'b0;
        gnt      = 1'b0;
        cycle();
        rst = 1'b0;
        check("rst_req", req, 1'b0);
        check("rst_fill", fill, 0);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_underrun", under, 0);
        check("rst_stall", stall, 0);
        check("rst_data", data_out, 0);
    endtask

    task automatic push_disabled(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + DW'(i);
            cycle();
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        rate_div = '0;
        wr_valid = 1'b0;
        wr_data  = '0;
        gnt      = 1'b0;
        @(posedge clk);
        #1;

        // Basic stream
        do_reset();
        rate_div = 3;
        push_disabled(4, 16'h0001);
        gnt      = 1'b1;
        enable   = 1'b1;
        req_seen = 0;
        for (int i = 0; i < 18; i++) cycle();
        enable = 1'b0;
        check("basic_req_pulses", req_seen, 4);
        check("basic_fill", fill, 0);
        check("basic_underrun", under, 0);
        check("basic_stall", stall, 0);
        check("basic_all_out", exp_q.size(), 0);

        // Backpressure
        do_reset();
        rate_div = 0;
        push_disabled(1, 16'hA5A5);
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("bp_req_held", req, 1'b1);
            check("bp_data_held", data_out, 16'hA5A5);
        end
        check("bp_stall9", stall, 9);
        gnt = 1'b1;
        cycle();
        gnt    = 1'b0;
        enable = 1'b0;
        check("bp_req_drop", req, 1'b0);
        check("bp_stall_after", stall, 9);
        cycle();

        // Underrun
        do_reset();
        rate_div = 1;
        enable   = 1'b1;
        req_seen = 0;
        for (int i = 0; i < 8; i++) cycle();
        check("ur_count4", under, 4);
        check("ur_no_req", req_seen, 0);
        wr_valid = 1'b1;
        wr_data  = 16'h1234;
        cycle();
        wr_valid = 1'b0;
        for (int i = 0; i < 4 && req !== 1'b1; i++) cycle();
        check("ur_req_after_push", req, 1'b1);
        check("ur_data", data_out, 16'h1234);
        gnt = 1'b1;
        cycle();
        gnt    = 1'b0;
        enable = 1'b0;
        cycle();

        // Full FIFO
        do_reset();
        push_disabled(17, 16'h0100);
        check("full_ready_low", wr_ready, 1'b0);
        check("full_fill16", fill, 16);
        rate_div = 0;
        gnt      = 1'b1;
        enable   = 1'b1;
        cycle();
        check("full_ready_after_pop", wr_ready, 1'b1);
        for (int i = 0; i < 40 && (exp_q.size() != 0 || req === 1'b1); i++) cycle();
        check("full_drained", exp_q.size(), 0);
        check("full_fill0", fill, 0);
        enable = 1'b0;
        gnt    = 1'b0;
        cycle();

        // Reset mid-request
        do_reset();
        push_disabled(6, 16'h0200);
        rate_div = 0;
        enable   = 1'b1;
        cycle();
        enable = 1'b0;
        check("mid_req_pending", req, 1'b1);
        check("mid_fill5", fill, 5);
        do_reset();

        // Saturation
        rate_div = 0;
        enable   = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        check("sat_underrun", under, CNT_MAX);
        cycle();
        check("sat_hold", under, CNT_MAX);
        enable = 1'b0;

        // Random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            if (!enable) rate_div = RW'($urandom_range(0, 3));
            wr_valid = $urandom_range(0, 1);
            wr_data  = DW'($urandom);
            gnt      = (req === 1'b1) && ($urandom_range(0, 2) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
